// File: rtl/alu_result_tx_sequencer.sv
// alu_result_tx_sequencer: sends a latched ALU result as uppercase ASCII hex plus a delimiter over UART TX.
// Optional ZERO_SUPPRESS_EN drops leading zero digits (at least one digit is always sent).
module alu_result_tx_sequencer #(
    parameter int          DATA_W = 32,
    parameter logic [7:0]  DELIM  = 8'h20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] result,
    input  logic              tx_done,
    output logic              tx_start,
    output logic [7:0]        d_out,
    output logic              busy,
    output logic              done
);
    localparam int N  = DATA_W / 4;
    localparam int CW = N > 1 ? $clog2(N) : 1;

    typedef enum logic [2:0] {IDLE, SKIP, SEND, WAIT, DLM, DONE} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] sr;
    logic              tx_done_q;
    logic              is_delim;
    logic              ack;
    logic [3:0]        nib;

    assign ack = tx_done & ~tx_done_q;
    assign nib = 4'(sr >> (4 * cnt));

    function automatic logic [7:0] hex(input logic [3:0] n);
        return n < 4'd10 ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            tx_start  <= 1'b0;
            d_out     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            cnt       <= CW'(N - 1);
            sr        <= '0;
            tx_done_q <= 1'b0;
            is_delim  <= 1'b0;
        end else begin
            tx_done_q <= tx_done;
            tx_start  <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sr   <= result;
                    cnt  <= CW'(N - 1);
                    busy <= 1'b1;
`ifdef ZERO_SUPPRESS_EN
                    state <= SKIP;
`else
                    state <= SEND;
`endif
                end
`ifdef ZERO_SUPPRESS_EN
                // Emits the first significant digit directly once no leading zero remains
                SKIP: if (cnt != '0 && nib == 4'h0) cnt <= cnt - CW'(1);
                else begin
                    tx_start <= 1'b1;
                    d_out    <= hex(nib);
                    state    <= WAIT;
                end
`endif
                SEND: begin
                    tx_start <= 1'b1;
                    d_out    <= hex(nib);
                    state    <= WAIT;
                end
                WAIT: if (ack) begin
                    if (is_delim) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else if (cnt == '0) state <= DLM;
                    else begin
                        cnt   <= cnt - CW'(1);
                        state <= SEND;
                    end
                end
                DLM: begin
                    tx_start <= 1'b1;
                    d_out    <= DELIM;
                    is_delim <= 1'b1;
                    state    <= WAIT;
                end
                DONE: begin
                    busy     <= 1'b0;
                    is_delim <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_result_tx_sequencer.sv
// tb_alu_result_tx_sequencer: randomized and directed checks of the hex byte stream against a string-based model.
module tb_alu_result_tx_sequencer;
    localparam int D = 8;

    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, tx_done = 1'b0;
    logic [31:0] result = '0;
    logic        tx_start, busy, done;
    logic [7:0]  d_out;

    int total = 0, bad = 0, n_ts = 0, n_done = 0;
    logic [7:0] exp_q[$];
    int exp_lat;

    alu_result_tx_sequencer #(.DATA_W(32), .DELIM(8'h20)) dut (
        .clk(clk), .reset(reset), .start(start), .result(result), .tx_done(tx_done),
        .tx_start(tx_start), .d_out(d_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start) n_ts++;
        if (done) n_done++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    task automatic build(input logic [31:0] r);
        string hx = "0123456789ABCDEF";
        int first = D - 1;
`ifdef ZERO_SUPPRESS_EN
        while (first > 0 && r[4*first +: 4] == 4'h0) first--;
`endif
        exp_q.delete();
        for (int i = first; i >= 0; i--) exp_q.push_back(hx[r[4*i +: 4]]);
        exp_q.push_back(8'h20);
        exp_lat = 2 + (D - 1 - first);
    endtask

    // mode 0 plain, 1 stray start on 3rd byte, 2 tx_done held high into WAIT, 3 reset on 4th digit
    task automatic run(input logic [31:0] r, input int mode, input int fixed_dly);
        int ts0, dn0, c, dly;
        logic [7:0] held;
        build(r);
        ts0 = n_ts;
        dn0 = n_done;
        @(negedge clk);
        result = r;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        c = 1;
        while (!tx_start && c < 40) begin
            @(negedge clk);
            c++;
        end
        chk("first_latency", c, exp_lat);
        if (!tx_start) return;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i > 0) begin
                c = 0;
                while (!tx_start && c < 40) begin
                    @(negedge clk);
                    c++;
                end
                if (!tx_start) begin
                    chk("ts_timeout", 0, 1);
                    return;
                end
            end
            chk("byte", d_out, exp_q[i]);
            held = d_out;
            if (mode == 3 && i == 3) begin
                reset = 1'b1;
                start = 1'b1;
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                chk("rst_tx_start", tx_start, 0);
                chk("rst_d_out", d_out, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                @(negedge clk);
                chk("rst_start_lost", busy, 0);
                return;
            end
            if (tx_done) begin
                repeat (4) begin
                    @(negedge clk);
                    chk("held_stable", d_out, held);
                    chk("held_no_ts", tx_start, 0);
                end
                tx_done = 1'b0;
                @(negedge clk);
            end
            if (mode == 1 && i == 2) begin
                start  = 1'b1;
                result = 32'h12345678;
                @(negedge clk);
                start = 1'b0;
                chk("stray_stable", d_out, held);
            end
            dly = fixed_dly >= 0 ? fixed_dly : int'($urandom_range(0, 4));
            repeat (dly) begin
                @(negedge clk);
                chk("wait_stable", d_out, held);
                chk("wait_no_ts", tx_start, 0);
            end
            tx_done = 1'b1;
            @(negedge clk);
            if (!(mode == 2 && i == 0)) tx_done = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("busy_in_done", busy, 1);
        @(negedge clk);
        chk("done_low", done, 0);
        chk("busy_low", busy, 0);
        chk("ts_count", n_ts - ts0, exp_q.size());
        chk("done_count", n_done - dn0, 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_tx_start", tx_start, 0);
        chk("reset_d_out", d_out, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;
        run(32'hDEADBEEF, 0, 5);
        run(32'h0000002A, 0, -1);
        run(32'h00000000, 0, -1);
        run(32'hDEADBEEF, 1, -1);
        run(32'hDEADBEEF, 2, -1);
        run(32'hDEADBEEF, 3, -1);
        run(32'h00000001, 0, -1);
        for (int k = 0; k < 24; k++) run($urandom >> $urandom_range(0, 31), 0, -1);
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
